inst_fetch_unit: RTL and testbench

Instruction-fetch stage of the single-cycle-to-pipelined MIPS core: owns the program counter, drives the word address into the instruction ROM, and registers the returned instruction into the IF/ID pipeline register for the decoder. Next-PC selection covers sequential fetch, `beq` redirect and `j` redirect. Stall and flush inputs come from the hazard/control unit.

---
 rtl/inst_fetch_unit.sv | 79 +++++++
 tb/tb_inst_fetch_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// registers the fetched word (plus its PC+4) into the IF/ID pipeline register.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] id_pc4,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic [31:0] pc,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  logic [31:0] r_pc;
  logic [31:0] r_if_id_inst;
  logic [31:0] r_if_id_pc4;
  logic        r_if_id_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;
  logic [31:0] w_pc_next;
  logic        w_redirect;

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_branch_target = id_pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign w_jump_target   = {id_pc4[31:28], jump_index, 2'b00};
  assign w_redirect      = branch_taken | jump;

  // Redirects outrank stall; branch outranks jump when both resolve together.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (branch_taken) begin
      w_pc_next = w_branch_target;
    end else if (jump) begin
      w_pc_next = w_jump_target;
    end else if (stall) begin
      w_pc_next = r_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // Any redirect or flush squashes the word fetched down the wrong path.
  always_ff @(posedge clk) begin
    if (rst || w_redirect || flush) begin
      r_if_id_inst  <= NOP_INST;
      r_if_id_pc4   <= 32'd0;
      r_if_id_valid <= 1'b0;
    end else if (!stall) begin
      r_if_id_inst  <= rom_inst;
      r_if_id_pc4   <= w_pc_plus4;
      r_if_id_valid <= 1'b1;
    end
  end

  assign pc          = r_pc;
  assign rom_addr    = r_pc;
  assign if_id_inst  = r_if_id_inst;
  assign if_id_pc4   = r_if_id_pc4;
  assign if_id_valid = r_if_id_valid;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed vector table, a hand-written redirect
// sequence, then randomized traffic against a behavioural fetch model.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, flush, branch_taken, jump;
  logic [15:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] id_pc4, rom_addr, rom_inst, pc, if_id_inst, if_id_pc4;
  logic        if_id_valid;

  logic [31:0] rom [0:255];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign rom_inst = rom[rom_addr[9:2]];

  inst_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index), .id_pc4(id_pc4),
    .rom_addr(rom_addr), .rom_inst(rom_inst), .pc(pc),
    .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
  );

  function automatic logic [31:0] romw(input int idx);
    return 32'hA000_0000 + 32'(idx);
  endfunction

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        br;
    logic [15:0] off;
    logic        jmp;
    logic [25:0] idx;
    logic [31:0] idpc4;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
    logic        e_valid;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [0:NV-1];

  function automatic vec_t mk(input logic r, s, f, b, input logic [15:0] o,
                              input logic j, input logic [25:0] ix,
                              input logic [31:0] ip, ep, ei, e4, input logic ev);
    vec_t v;
    v = '{rst: r, stall: s, flush: f, br: b, off: o, jmp: j, idx: ix,
          idpc4: ip, e_pc: ep, e_inst: ei, e_pc4: e4, e_valid: ev};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, s, f, b, input logic [15:0] o,
                       input logic j, input logic [25:0] ix, input logic [31:0] ip);
    rst = r; stall = s; flush = f; branch_taken = b; branch_offset = o;
    jump = j; jump_index = ix; id_pc4 = ip;
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, e_inst, e_pc4,
                           input logic e_valid);
    check({tag, " pc"}, pc, e_pc);
    check({tag, " rom_addr"}, rom_addr, e_pc);
    check({tag, " inst"}, if_id_inst, e_inst);
    check({tag, " pc4"}, if_id_pc4, e_pc4);
    check({tag, " valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
  endtask

  // Behavioural model state
  logic [31:0] m_pc, m_inst, m_pc4;
  logic        m_valid;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = romw(i);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);

    //           rst  stl  fl   br   off      jmp  idx          id_pc4        pc            inst         pc4           v
    vecs[0]  = mk(1'b1,1'b1,1'b0,1'b0,16'h0000,1'b0,26'h0,      32'h0,        32'h0,        32'h0,       32'h0,        1'b0);
    vecs[1]  = mk(1'b1,1'b1,1'b0,1'b0,16'h0000,1'b0,26'h0,      32'h0,        32'h0,        32'h0,       32'h0,        1'b0);
    vecs[2]  = mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h0,      32'h0,        32'h4,        romw(0),     32'h4,        1'b1);
    vecs[3]  = mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h0,      32'h0,        32'h8,        romw(1),     32'h8,        1'b1);
    vecs[4]  = mk(1'b0,1'b1,1'b0,1'b0,16'h0000,1'b0,26'h0,      32'h0,        32'h8,        romw(1),     32'h8,        1'b1);
    vecs[5]  = mk(1'b0,1'b1,1'b0,1'b0,16'h0000,1'b0,26'h0,      32'h0,        32'h8,        romw(1),     32'h8,        1'b1);
    vecs[6]  = mk(1'b0,1'b1,1'b0,1'b0,16'h0000,1'b0,26'h0,      32'h0,        32'h8,        romw(1),     32'h8,        1'b1);
    vecs[7]  = mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h0,      32'h0,        32'hC,        romw(2),     32'hC,        1'b1);
    vecs[8]  = mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h0,      32'h0,        32'h10,       romw(3),     32'h10,       1'b1);
    vecs[9]  = mk(1'b0,1'b0,1'b0,1'b1,16'hFFFE,1'b0,26'h0,      32'h10,       32'h8,        32'h0,       32'h0,        1'b0);
    vecs[10] = mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h0,      32'h0,        32'hC,        romw(2),     32'hC,        1'b1);
    vecs[11] = mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b1,26'h40,     32'h1000_0010,32'h1000_0100,32'h0,       32'h0,        1'b0);
    vecs[12] = mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h0,      32'h0,        32'h1000_0104,romw(8'h40), 32'h1000_0104,1'b1);
    vecs[13] = mk(1'b0,1'b0,1'b0,1'b1,16'h0001,1'b1,26'h40,     32'h1000_0010,32'h1000_0014,32'h0,       32'h0,        1'b0);
    vecs[14] = mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h0,      32'h0,        32'h1000_0018,romw(5),     32'h1000_0018,1'b1);
    vecs[15] = mk(1'b0,1'b0,1'b1,1'b0,16'h0000,1'b0,26'h0,      32'h0,        32'h1000_001C,32'h0,       32'h0,        1'b0);
    vecs[16] = mk(1'b0,1'b1,1'b1,1'b0,16'h0000,1'b0,26'h0,      32'h0,        32'h1000_001C,32'h0,       32'h0,        1'b0);
    vecs[17] = mk(1'b0,1'b1,1'b0,1'b1,16'h0004,1'b0,26'h0,      32'h20,       32'h30,       32'h0,       32'h0,        1'b0);
    vecs[18] = mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b1,26'h3FFFFFF,32'hF000_0000,32'hFFFF_FFFC,32'h0,       32'h0,        1'b0);
    vecs[19] = mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h0,      32'h0,        32'h0,        romw(255),   32'h0,        1'b1);
    vecs[20] = mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h0,      32'h0,        32'h4,        romw(0),     32'h4,        1'b1);
    vecs[21] = mk(1'b0,1'b1,1'b0,1'b0,16'h0000,1'b0,26'h0,      32'h0,        32'h4,        romw(0),     32'h4,        1'b1);
    vecs[22] = mk(1'b1,1'b1,1'b0,1'b1,16'h0004,1'b0,26'h0,      32'h20,       32'h0,        32'h0,       32'h0,        1'b0);
    vecs[23] = mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,26'h0,      32'h0,        32'h4,        romw(0),     32'h4,        1'b1);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].off,
            vecs[i].jmp, vecs[i].idx, vecs[i].idpc4);
      @(posedge clk); #1;
      $display("[TB] vec %0d: pc=%08h inst=%08h pc4=%08h valid=%0b",
               i, pc, if_id_inst, if_id_pc4, if_id_valid);
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_pc4, vecs[i].e_valid);
    end

    // Redirect latency: bubble in n+1, target word in n+2, resume after a stall.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'h80, 32'h0000_0040);
    @(posedge clk); #1;
    $display("[TB] seq jump: pc=%08h valid=%0b", pc, if_id_valid);
    check_all("seq_jump", 32'h200, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      $display("[TB] seq stall %0d: pc=%08h valid=%0b", k, pc, if_id_valid);
      check_all("seq_stall_after_jump", 32'h200, 32'h0, 32'h0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 32'h0);
    @(posedge clk); #1;
    $display("[TB] seq resume: pc=%08h inst=%08h", pc, if_id_inst);
    check_all("seq_target", 32'h204, romw(8'h80), 32'h204, 1'b1);

    // Randomized traffic against the behavioural model.
    m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    for (int t = 0; t < 300; t++) begin
      logic        r, s, f, b, j;
      logic [15:0] o;
      logic [25:0] ix;
      logic [31:0] ip, tgt;
      r  = (t == 0) || ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 9) == 0);
      b  = ($urandom_range(0, 9) == 0);
      j  = ($urandom_range(0, 9) == 0);
      o  = 16'($urandom);
      ix = 26'($urandom);
      ip = $urandom & 32'hFFFF_FFFC;
      drive(r, s, f, b, o, j, ix, ip);

      // IF/ID sees the word fetched at the pre-edge PC.
      if (r || b || j || f) begin
        m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (!s) begin
        m_inst = romw(int'(m_pc[9:2])); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      end
      if (r)       tgt = 32'h0;
      else if (b)  tgt = ip + (32'($signed(o)) * 4);
      else if (j)  tgt = (ip & 32'hF000_0000) + (32'(ix) << 2);
      else if (s)  tgt = m_pc;
      else         tgt = m_pc + 32'd4;
      m_pc = tgt;

      @(posedge clk); #1;
      $display("[TB] rnd %0d: rst=%0b stl=%0b fl=%0b br=%0b j=%0b pc=%08h inst=%08h valid=%0b",
               t, r, s, f, b, j, pc, if_id_inst, if_id_valid);
      check_all($sformatf("rnd%0d", t), m_pc, m_inst, m_pc4, m_valid);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
